cpu_bus_arbiter: RTL and testbench

CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

---
 rtl/cpu_bus_arbiter_pkg.sv | 45 ++++
 rtl/cpu_bus_arbiter_if.sv | 29 ++
 rtl/rr_arbiter2.sv | 19 +
 rtl/cpu_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types, widths and command codes for the two-requester cache CPU-port arbiter.
package cpu_bus_arbiter_pkg;

    localparam int unsigned CMD_W  = 3;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    localparam logic [CMD_W-1:0] NOP  = 3'd0;
    localparam logic [CMD_W-1:0] RD8  = 3'd1;
    localparam logic [CMD_W-1:0] RD16 = 3'd2;
    localparam logic [CMD_W-1:0] RD32 = 3'd3;
    localparam logic [CMD_W-1:0] INV  = 3'd4;
    localparam logic [CMD_W-1:0] WR8  = 3'd5;
    localparam logic [CMD_W-1:0] WR16 = 3'd6;
    localparam logic [CMD_W-1:0] WR32 = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    // Read responses are trimmed to the access width; writes/invalidates return zero.
    function automatic logic [DATA_W-1:0] mask_rdata(input logic [CMD_W-1:0] cmd,
                                                     input logic [DATA_W-1:0] data);
        case (cmd)
            RD8:  return DATA_W'(data[7:0]);
            RD16: return DATA_W'(data[15:0]);
            RD32: return data;
            NOP, INV, WR8, WR16, WR32: return '0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// Requester-side and cache-side bus of the arbiter; slave = arbiter, master = environment.
interface cpu_bus_arbiter_if;
    import cpu_bus_arbiter_pkg::*;

    logic [2*CMD_W-1:0]  req_cmd;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_ack;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_err;
    logic [DATA_W-1:0]   rsp_data;
    logic [CMD_W-1:0]    c_cmd;
    logic [ADDR_W-1:0]   c_addr;
    logic [DATA_W-1:0]   c_wdata;
    logic                c_done;
    logic [DATA_W-1:0]   c_rdata;
    logic [2*CNT_W-1:0]  grant_cnt;

    modport slave (
        input  req_cmd, req_addr, req_wdata, c_done, c_rdata,
        output req_ack, rsp_valid, rsp_err, rsp_data, c_cmd, c_addr, c_wdata, grant_cnt
    );

    modport master (
        output req_cmd, req_addr, req_wdata, c_done, c_rdata,
        input  req_ack, rsp_valid, rsp_err, rsp_data, c_cmd, c_addr, c_wdata, grant_cnt
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: the favoured requester wins only when both are pending.
module rr_arbiter2 (
    input  logic [1:0] pending,
    input  logic       prio,
    output logic       pick_c,
    output logic       valid_c
);

    always_comb begin
        valid_c = |pending;
        pick_c  = 1'b0;
        case (pending)
            2'b10:   pick_c = 1'b1;
            2'b11:   pick_c = prio;
            default: pick_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Arbitrates two CPU requesters onto a single cache port: grant, issue one cycle, wait for done or timeout.
module cpu_bus_arbiter
    import cpu_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    cpu_bus_arbiter_if.slave        bus
);

    state_e              state_q, state_d;
    txn_t                txn_q, txn_d;
    logic                owner_q, owner_d;
    logic                prio_q, prio_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic [CNT_W-1:0]    cnt0_q, cnt0_d;
    logic [CNT_W-1:0]    cnt1_q, cnt1_d;
    logic [1:0]          ack_q, ack_d;
    logic [1:0]          valid_q, valid_d;
    logic [1:0]          err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CMD_W-1:0]    ccmd_q, ccmd_d;

    txn_t                req_txn [2];
    logic [1:0]          pending;
    logic                pick_c;
    logic                pick_valid_c;

    // Unpack the two requester lanes.
    assign req_txn[0] = {bus.req_cmd[CMD_W-1:0], bus.req_addr[ADDR_W-1:0],
                         bus.req_wdata[DATA_W-1:0]};
    assign req_txn[1] = {bus.req_cmd[2*CMD_W-1:CMD_W], bus.req_addr[2*ADDR_W-1:ADDR_W],
                         bus.req_wdata[2*DATA_W-1:DATA_W]};
    assign pending    = {|req_txn[1].cmd, |req_txn[0].cmd};

    rr_arbiter2 u_rr (
        .pending (pending),
        .prio    (prio_q),
        .pick_c  (pick_c),
        .valid_c (pick_valid_c)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        txn_d   = txn_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        wcnt_d  = wcnt_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        ack_d   = '0;
        valid_d = '0;
        err_d   = '0;
        rdata_d = '0;
        ccmd_d  = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    owner_d       = pick_c;
                    prio_d        = ~pick_c;
                    txn_d         = req_txn[pick_c];
                    ack_d[pick_c] = 1'b1;
                    ccmd_d        = req_txn[pick_c].cmd;
                    state_d       = ISSUE;
                    if (pick_c) cnt1_d = sat_inc(cnt1_q);
                    else        cnt0_d = sat_inc(cnt0_q);
                end
            end
            ISSUE: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Completion takes precedence over a timeout landing in the same cycle.
                if (bus.c_done) begin
                    valid_d[owner_q] = 1'b1;
                    rdata_d          = mask_rdata(txn_q.cmd, bus.c_rdata);
                    state_d          = IDLE;
                end else if (wcnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d[owner_q] = 1'b1;
                    state_d        = IDLE;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            txn_q   <= '0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            wcnt_q  <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            ack_q   <= '0;
            valid_q <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            ccmd_q  <= '0;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            wcnt_q  <= wcnt_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            ccmd_q  <= ccmd_d;
        end
    end

    assign bus.req_ack   = ack_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_data  = rdata_q;
    assign bus.c_cmd     = ccmd_q;
    assign bus.c_addr    = txn_q.addr;
    assign bus.c_wdata   = txn_q.wdata;
    assign bus.grant_cnt = {cnt1_q, cnt0_q};

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: read, contention, timeout, tie, reset mid-WAIT, counter saturation.
module tb_cpu_bus_arbiter;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    cpu_bus_arbiter_if bus ();

    cpu_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_outputs(input string tag);
        check({tag, " ack/valid/err/c_cmd"},
              64'({bus.req_ack, bus.rsp_valid, bus.rsp_err, bus.c_cmd}), 64'(0));
        check({tag, " rsp_data"}, 64'(bus.rsp_data), 64'(0));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset         = 1'b0;
        bus.req_cmd   = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.c_done    = 1'b0;
        bus.c_rdata   = '0;
        step();
        step();

        // Reset state
        idle_outputs("reset");
        check("reset c_addr/c_wdata", 64'({bus.c_addr, bus.c_wdata}), 64'(0));
        check("reset grant_cnt", 64'(bus.grant_cnt), 64'(0));

        // Single RD32 from r0
        reset            = 1'b1;
        bus.req_cmd      = {3'd0, 3'd3};
        bus.req_addr     = {14'h0, 14'h0123};
        bus.req_wdata    = {32'h0, 32'h0BAD_F00D};
        step();
        check("rd32 ack", 64'(bus.req_ack), 64'(2'b01));
        check("rd32 c_cmd", 64'(bus.c_cmd), 64'(3));
        check("rd32 c_addr", 64'(bus.c_addr), 64'(14'h0123));
        check("rd32 grant_cnt", 64'(bus.grant_cnt), 64'(32'h0000_0001));
        bus.req_cmd = '0;
        step();
        check("rd32 c_cmd after issue", 64'(bus.c_cmd), 64'(0));
        check("rd32 c_addr held", 64'(bus.c_addr), 64'(14'h0123));
        check("rd32 ack one cycle", 64'(bus.req_ack), 64'(0));
        step();
        step();
        bus.c_done  = 1'b1;
        bus.c_rdata = 32'hDEAD_BEEF;
        step();
        bus.c_done  = 1'b0;
        check("rd32 valid", 64'(bus.rsp_valid), 64'(2'b01));
        check("rd32 data", 64'(bus.rsp_data), 64'(32'hDEAD_BEEF));
        check("rd32 err", 64'(bus.rsp_err), 64'(0));

        // Stray c_done in IDLE must be ignored
        bus.c_done = 1'b1;
        step();
        bus.c_done = 1'b0;
        idle_outputs("stray done");
        step();
        idle_outputs("stray done +1");

        // Contention: both hold RD16 from reset
        reset        = 1'b0;
        bus.req_cmd  = {3'd2, 3'd2};
        bus.req_addr = {14'h1555, 14'h0AAA};
        step();
        check("contention reset grant_cnt", 64'(bus.grant_cnt), 64'(0));
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("contention ack", 64'(bus.req_ack), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
            check("contention c_addr", 64'(bus.c_addr),
                  64'((k % 2 == 0) ? 14'h0AAA : 14'h1555));
            step();
            bus.c_done  = 1'b1;
            bus.c_rdata = {16'hFACE, 16'(16'h1000 + k)};
            if (k == 3) bus.req_cmd = '0;
            step();
            bus.c_done = 1'b0;
            check("contention valid", 64'(bus.rsp_valid), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
            check("contention data rd16", 64'(bus.rsp_data), 64'(16'h1000 + k));
        end
        check("contention grant_cnt", 64'(bus.grant_cnt), 64'(32'h0002_0002));

        // Timeout: r1 WR16, no completion
        bus.req_cmd   = {3'd6, 3'd0};
        bus.req_addr  = {14'h2222, 14'h0};
        bus.req_wdata = {32'h55AA_55AA, 32'h0};
        step();
        check("timeout ack", 64'(bus.req_ack), 64'(2'b10));
        check("timeout c_cmd", 64'(bus.c_cmd), 64'(6));
        check("timeout c_wdata", 64'(bus.c_wdata), 64'(32'h55AA_55AA));
        bus.req_cmd = '0;
        step();
        step();
        step();
        step();
        check("timeout err early", 64'(bus.rsp_err), 64'(0));
        step();
        check("timeout err", 64'(bus.rsp_err), 64'(2'b10));
        check("timeout valid", 64'(bus.rsp_valid), 64'(0));

        // Next request served normally: r0 RD8
        bus.req_cmd  = {3'd0, 3'd1};
        bus.req_addr = {14'h0, 14'h0010};
        step();
        check("post-timeout ack", 64'(bus.req_ack), 64'(2'b01));
        bus.req_cmd = '0;
        step();
        bus.c_done  = 1'b1;
        bus.c_rdata = 32'h1234_5678;
        step();
        bus.c_done = 1'b0;
        check("rd8 valid", 64'(bus.rsp_valid), 64'(2'b01));
        check("rd8 data", 64'(bus.rsp_data), 64'(32'h0000_0078));

        // Tie: c_done on the last WAIT cycle
        bus.req_cmd = {3'd0, 3'd7};
        step();
        check("tie ack", 64'(bus.req_ack), 64'(2'b01));
        bus.req_cmd = '0;
        step();
        step();
        step();
        step();
        bus.c_done  = 1'b1;
        bus.c_rdata = 32'hFFFF_FFFF;
        step();
        bus.c_done = 1'b0;
        check("tie valid", 64'(bus.rsp_valid), 64'(2'b01));
        check("tie err", 64'(bus.rsp_err), 64'(0));
        check("tie write data", 64'(bus.rsp_data), 64'(0));

        // Reset in the middle of WAIT
        bus.req_cmd  = {3'd0, 3'd3};
        bus.req_addr = {14'h0, 14'h3FFF};
        step();
        bus.req_cmd = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        idle_outputs("midreset");
        check("midreset c_addr/c_wdata", 64'({bus.c_addr, bus.c_wdata}), 64'(0));
        check("midreset grant_cnt", 64'(bus.grant_cnt), 64'(0));
        bus.c_done  = 1'b1;
        bus.c_rdata = 32'hAAAA_AAAA;
        step();
        bus.c_done   = 1'b0;
        bus.req_cmd  = {3'd1, 3'd0};
        bus.req_addr = {14'h0042, 14'h0};
        reset        = 1'b1;
        step();
        check("post-reset ack", 64'(bus.req_ack), 64'(2'b10));
        check("post-reset no rsp", 64'({bus.rsp_valid, bus.rsp_err}), 64'(0));
        check("post-reset grant_cnt", 64'(bus.grant_cnt), 64'(32'h0001_0000));
        bus.req_cmd = '0;
        step();
        bus.c_done  = 1'b1;
        bus.c_rdata = 32'h0000_01C3;
        step();
        bus.c_done = 1'b0;
        check("post-reset valid", 64'(bus.rsp_valid), 64'(2'b10));
        check("post-reset rd8 data", 64'(bus.rsp_data), 64'(32'h0000_00C3));

        // Saturation: counter preloaded one below the ceiling
        dut.cnt0_q  = 16'hFFFE;
        bus.req_cmd = {3'd0, 3'd4};
        for (int k = 0; k < 2; k++) begin
            step();
            check("sat ack", 64'(bus.req_ack), 64'(2'b01));
            check("sat grant_cnt", 64'(bus.grant_cnt), 64'(32'h0001_FFFF));
            bus.req_cmd = '0;
            step();
            bus.c_done  = 1'b1;
            bus.c_rdata = 32'h1357_9BDF;
            step();
            bus.c_done = 1'b0;
            check("sat inv valid", 64'(bus.rsp_valid), 64'(2'b01));
            check("sat inv data", 64'(bus.rsp_data), 64'(0));
            bus.req_cmd = {3'd0, 3'd4};
        end
        bus.req_cmd = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
